// File: rtl/identity_chk_pkg.sv
// Shared constants and state encoding for the identity response checker.
package identity_chk_pkg;

  localparam int unsigned WIDTH_DEF    = 87;
  localparam int unsigned NUM_VECS_DEF = 21;
  localparam int unsigned CNT_W_DEF    = 16;

  localparam logic [86:0] MISR_POLY = 87'h0000_0000_0000_0000_0041;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/identity_misr.sv
// Multiple-input signature register compacting one vector per enabled edge.
module identity_misr #(
  parameter int unsigned      WIDTH = 87,
  parameter logic [WIDTH-1:0] POLY  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sig
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sig <= '0;
    end else if (en) begin
      sig <= {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? POLY : '0) ^ din;
    end
  end

endmodule

// File: rtl/identity_response_checker.sv
// Compares RTL and netlist output vectors per sample, counts mismatches, signs y_dut.
// Optional IDENTITY_DIFF_CAPTURE_EN adds diff_mask holding the first mismatching XOR.
module identity_response_checker
  import identity_chk_pkg::*;
#(
  parameter int unsigned WIDTH    = WIDTH_DEF,
  parameter int unsigned NUM_VECS = NUM_VECS_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             valid,
  input  logic [WIDTH-1:0] y_ref,
  input  logic [WIDTH-1:0] y_dut,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] first_fail_idx,
`ifdef IDENTITY_DIFF_CAPTURE_EN
  output logic [WIDTH-1:0] diff_mask,
`endif
  output logic [WIDTH-1:0] signature
);

  localparam int unsigned SW = $clog2(NUM_VECS + 1);

  state_t          state, state_next;
  logic [SW-1:0]   sample_cnt;
  logic            clear;
  logic            take;
  logic            mismatch;
  logic            last_sample;

  // The entry edge only clears: take is gated by state, which is not yet RUN.
  assign clear       = start && (state != RUN);
  assign take        = (state == RUN) && valid;
  assign mismatch    = |(y_ref ^ y_dut);
  assign last_sample = (sample_cnt == SW'(NUM_VECS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (take && last_sample) state_next = DONE;
      DONE:    if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sample_cnt     <= '0;
      mismatch_cnt   <= '0;
      first_fail_idx <= '1;
    end else if (take) begin
      sample_cnt <= sample_cnt + 1'b1;
      if (mismatch) begin
        if (mismatch_cnt != '1) begin
          mismatch_cnt <= mismatch_cnt + 1'b1;
        end
        if (first_fail_idx == '1) begin
          first_fail_idx <= CNT_W'(sample_cnt);
        end
      end
    end
  end

`ifdef IDENTITY_DIFF_CAPTURE_EN
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      diff_mask <= '0;
    end else if (take && mismatch && (first_fail_idx == '1)) begin
      diff_mask <= y_ref ^ y_dut;
    end
  end
`endif

  identity_misr #(
    .WIDTH (WIDTH),
    .POLY  (WIDTH'(MISR_POLY))
  ) u_misr (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .en    (take),
    .din   (y_dut),
    .sig   (signature)
  );

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign pass = done && (mismatch_cnt == '0);

endmodule

// File: tb/tb_identity_response_checker.sv
// Directed/randomized bench for identity_response_checker against a run-level reference model.
module tb_identity_response_checker;

  localparam logic [86:0] POLY = 87'h0000_0000_0000_0000_0041;
  localparam int NV = 21;

  logic        clk = 1'b0;
  logic        rst, start, valid;
  logic [86:0] y_ref, y_dut;
  logic        busy, done, pass;
  logic [15:0] mismatch_cnt, first_fail_idx;
  logic [86:0] signature;
`ifdef IDENTITY_DIFF_CAPTURE_EN
  logic [86:0] diff_mask;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: run status plus the quantities a run accumulates.
  bit          m_run, m_done;
  int          m_n;
  logic [15:0] m_cnt, m_idx;
  logic [86:0] m_sig, m_diff;

  identity_response_checker dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .valid          (valid),
    .y_ref          (y_ref),
    .y_dut          (y_dut),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .mismatch_cnt   (mismatch_cnt),
    .first_fail_idx (first_fail_idx),
`ifdef IDENTITY_DIFF_CAPTURE_EN
    .diff_mask      (diff_mask),
`endif
    .signature      (signature)
  );

  always #5 clk = ~clk;

  function automatic logic [86:0] rnd87();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[86:0];
  endfunction

  function automatic logic [86:0] misr_next(input logic [86:0] s, input logic [86:0] d);
    logic [86:0] sh;
    sh = s << 1;
    if (s[86]) sh = sh ^ POLY;
    return sh ^ d;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_n   = 0;
    m_cnt = 16'h0;
    m_idx = 16'hFFFF;
    m_sig = '0;
    m_diff = '0;
  endtask

  task automatic model_edge();
    if (rst) begin
      m_run = 0; m_done = 0;
      model_clear();
    end else if (!m_run && start) begin
      m_run = 1; m_done = 0;
      model_clear();
    end else if (m_run && valid) begin
      m_sig = misr_next(m_sig, y_dut);
      if (y_ref !== y_dut) begin
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (m_idx == 16'hFFFF) begin
          m_idx  = 16'(m_n);
          m_diff = y_ref ^ y_dut;
        end
      end
      m_n++;
      if (m_n == NV) begin
        m_run = 0; m_done = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_busy"}, 128'(busy), 128'(m_run));
    chk({tag, "_done"}, 128'(done), 128'(m_done));
    chk({tag, "_pass"}, 128'(pass), 128'(m_done && m_cnt == 16'h0));
    chk({tag, "_cnt"},  128'(mismatch_cnt), 128'(m_cnt));
    chk({tag, "_idx"},  128'(first_fail_idx), 128'(m_idx));
    chk({tag, "_sig"},  128'(signature), 128'(m_sig));
`ifdef IDENTITY_DIFF_CAPTURE_EN
    chk({tag, "_diff"}, 128'(diff_mask), 128'(m_diff));
`endif
  endtask

  task automatic cycle(input string tag, input logic r, input logic s, input logic v,
                       input logic [86:0] yr, input logic [86:0] yd);
    rst = r; start = s; valid = v; y_ref = yr; y_dut = yd;
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [86:0] d;
    rst = 1'b0; start = 1'b0; valid = 1'b0; y_ref = '0; y_dut = '0;
    m_run = 0; m_done = 0;
    model_clear();
    @(negedge clk);

    // Power-on reset
    cycle("rst0", 1, 0, 0, '0, '0);
    cycle("rst0", 1, 0, 0, '0, '0);
    chk("rst0_idx_ones", 128'(first_fail_idx), 128'(16'hFFFF));

    // 1: reset mid-run after 5 samples
    cycle("t1_go", 0, 1, 0, '0, '0);
    for (int i = 0; i < 5; i++) begin
      d = rnd87();
      cycle("t1_s", 0, 0, 1, d, d ^ 87'(i % 2));
    end
    cycle("t1_rst", 1, 0, 1, rnd87(), rnd87());
    cycle("t1_rst", 1, 0, 1, rnd87(), rnd87());
    chk("t1_busy0", 128'(busy), 128'(0));
    chk("t1_cnt0", 128'(mismatch_cnt), 128'(0));
    chk("t1_idx", 128'(first_fail_idx), 128'(16'hFFFF));
    chk("t1_sig0", 128'(signature), 128'(0));
    cycle("t1_idle", 0, 0, 1, 87'h5, 87'h6);

    // 2: all-zero run
    cycle("t2_go", 0, 1, 0, '0, '0);
    for (int i = 0; i < NV; i++) cycle("t2_s", 0, 0, 1, '0, '0);
    chk("t2_done", 128'(done), 128'(1));
    chk("t2_pass", 128'(pass), 128'(1));
    chk("t2_sig", 128'(signature), 128'(0));

    // 3: constant 1 run, signature from model
    cycle("t3_go", 0, 1, 0, '0, '0);
    for (int i = 0; i < NV; i++) cycle("t3_s", 0, 0, 1, 87'h1, 87'h1);
    chk("t3_pass", 128'(pass), 128'(1));
    chk("t3_sig_nz", 128'(signature != '0), 128'(1));

    // 4: mismatches on bit 86 at samples 3 and 7
    cycle("t4_go", 0, 1, 0, '0, '0);
    for (int i = 0; i < NV; i++) begin
      d = rnd87();
      cycle("t4_s", 0, 0, 1, d, (i == 3 || i == 7) ? (d ^ (87'h1 << 86)) : d);
    end
    chk("t4_cnt", 128'(mismatch_cnt), 128'(2));
    chk("t4_idx", 128'(first_fail_idx), 128'(3));
    chk("t4_pass", 128'(pass), 128'(0));
`ifdef IDENTITY_DIFF_CAPTURE_EN
    chk("t4_diff", 128'(diff_mask), 128'(87'h1 << 86));
`endif

    // 5: valid gaps with random data and occasional mismatches
    cycle("t5_go", 0, 1, 0, '0, '0);
    for (int i = 0; i < 2 * NV; i++) begin
      d = rnd87();
      cycle("t5_s", 0, 0, (i % 2) == 0, d,
            ($urandom_range(0, 3) == 0) ? (d ^ rnd87()) : d);
      if (i < 2 * NV - 2) chk("t5_busy", 128'(busy), 128'(1));
    end
    chk("t5_done", 128'(done), 128'(1));

    // 6: start in RUN ignored; start in DONE restarts (entry edge with valid takes no sample)
    cycle("t6_go", 0, 1, 0, '0, '0);
    for (int i = 0; i < NV; i++) begin
      d = rnd87();
      cycle("t6_s", 0, (i == 10), 1, d, (i == 12) ? ~d : d);
    end
    chk("t6_done", 128'(done), 128'(1));
    chk("t6_idx", 128'(first_fail_idx), 128'(12));
    cycle("t6_re", 0, 1, 1, 87'h3, 87'h4);
    chk("t6_cnt0", 128'(mismatch_cnt), 128'(0));
    chk("t6_sig0", 128'(signature), 128'(0));
    chk("t6_busy", 128'(busy), 128'(1));
    for (int i = 0; i < 4; i++) begin
      d = rnd87();
      cycle("t6_s2", 0, 0, 1, d, (i == 1) ? d ^ 87'h80 : d);
    end
    cycle("t6_gap", 0, 0, 0, rnd87(), rnd87());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
